// File: rtl/exc_commit_unit_pkg.sv
// Shared constants, types and the fixed-priority cause selector for the
// MEM-stage exception commit unit.
package exc_commit_unit_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BRK  = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam int FLG_ADEL_IF = 0;
  localparam int FLG_RI      = 1;
  localparam int FLG_SYS     = 2;
  localparam int FLG_BRK     = 3;
  localparam int FLG_OV      = 4;
  localparam int FLG_ADEL_LD = 5;
  localparam int FLG_ADES    = 6;
  localparam int FLG_ERET    = 7;

  typedef enum logic { S_IDLE, S_FLUSH } state_e;
  typedef enum logic [1:0] { BAD_NONE, BAD_PC, BAD_MEM } bad_src_e;

  typedef struct packed {
    logic [31:0] code;
    bad_src_e    bad_src;
  } exc_sel_t;

  function automatic exc_sel_t exc_select(input logic int_p, input logic [7:0] f);
    exc_sel_t s;
    s = '{code: 32'h0, bad_src: BAD_NONE};
    if (int_p)                 s.code = EXC_INT;
    else if (f[FLG_ADEL_IF]) begin s.code = EXC_ADEL; s.bad_src = BAD_PC; end
    else if (f[FLG_RI])        s.code = EXC_RI;
    else if (f[FLG_SYS])       s.code = EXC_SYS;
    else if (f[FLG_BRK])       s.code = EXC_BRK;
    else if (f[FLG_OV])        s.code = EXC_OV;
    else if (f[FLG_ADEL_LD]) begin s.code = EXC_ADEL; s.bad_src = BAD_MEM; end
    else if (f[FLG_ADES]) begin s.code = EXC_ADES; s.bad_src = BAD_MEM; end
    else if (f[FLG_ERET])      s.code = EXC_ERET;
    return s;
  endfunction

endpackage

// File: rtl/exc_commit_unit_int_sync.sv
// Multi-flop synchroniser for the asynchronous hardware interrupt lines.
module int_sync #(
  parameter int STAGES = 2,
  parameter int W      = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] pipe;

  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/exc_commit_unit.sv
// MEM-stage exception arbiter: picks one cause by priority, registers the
// CP0 exception inputs, flushes the pipe and blocks commits while draining.
module exc_commit_unit
  import exc_commit_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        int_pending_o
);

  logic [5:0] sync_int;
  logic [7:0] ip;
  logic       commit;
  exc_sel_t   sel;
  state_e     state;
  logic [2:0] drain_cnt;

  int_sync #(.STAGES(SYNC_STAGES), .W(6)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (int_i),
    .q   (sync_int)
  );

  // Interrupts are masked by IE=0 or EXL=1; synchronous exceptions are not.
  assign ip            = {sync_int, cause_i[9:8]} & status_i[15:8];
  assign int_pending_o = (|ip) & status_i[0] & ~status_i[1];

  assign sel    = exc_select(int_pending_o, exc_flags_i);
  assign commit = (state == S_IDLE) & valid_i & ~stall_i & (int_pending_o | (|exc_flags_i));

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      drain_cnt           <= '0;
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= '0;
      flush_o             <= 1'b0;
      newpc_o             <= '0;
    end else begin
      excepttype_o <= '0;
      flush_o      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (commit) begin
            excepttype_o        <= sel.code;
            current_inst_addr_o <= pc_i;
            is_in_delayslot_o   <= is_in_delayslot_i;
            flush_o             <= 1'b1;
            newpc_o             <= (sel.code == EXC_ERET) ? epc_i : EXC_VECTOR;
            if (sel.bad_src == BAD_PC)  bad_addr_o <= pc_i;
            if (sel.bad_src == BAD_MEM) bad_addr_o <= mem_addr_i;
            state     <= S_FLUSH;
            drain_cnt <= 3'(FLUSH_CYCLES);
          end
        end
        S_FLUSH: begin
          if (drain_cnt <= 3'd1) state <= S_IDLE;
          else                   drain_cnt <= drain_cnt - 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cause_i[31:10], cause_i[7:0], status_i[31:16], status_i[7:2]};

endmodule

// File: tb/tb_exc_commit_unit.sv
// Directed bench: table of single-instruction commits plus hand sequences
// for interrupts, stall, drain window and reset during drain.
module tb_exc_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i;
  logic [7:0]  exc_flags_i;
  logic [5:0]  int_i;

  logic [31:0] et1, ia1, bad1, np1, et3, ia3, bad3, np3;
  logic        ds1, fl1, ip1, ds3, fl3, ip3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exc_commit_unit u1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .mem_addr_i(mem_addr_i),
    .exc_flags_i(exc_flags_i), .int_i(int_i), .status_i(status_i),
    .cause_i(cause_i), .epc_i(epc_i), .excepttype_o(et1),
    .current_inst_addr_o(ia1), .is_in_delayslot_o(ds1), .bad_addr_o(bad1),
    .flush_o(fl1), .newpc_o(np1), .int_pending_o(ip1)
  );

  exc_commit_unit #(.FLUSH_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .mem_addr_i(mem_addr_i),
    .exc_flags_i(exc_flags_i), .int_i(int_i), .status_i(status_i),
    .cause_i(cause_i), .epc_i(epc_i), .excepttype_o(et3),
    .current_inst_addr_o(ia3), .is_in_delayslot_o(ds3), .bad_addr_o(bad3),
    .flush_o(fl3), .newpc_o(np3), .int_pending_o(ip3)
  );

  typedef struct {
    logic [7:0]  flags;
    logic [31:0] pc, mem, epc, status;
    logic        ds;
    logic [31:0] e_type, e_bad, e_newpc;
    logic        e_flush;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0; exc_flags_i = 8'h00; stall_i = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    //            flags  pc            mem           epc           status        ds  type   bad           newpc         flush
    vecs[0]  = '{8'h04, 32'hBFC00100, 32'h0,        32'h0,        32'h0,        0, 32'h08, 32'h0,        32'hBFC00380, 1};
    vecs[1]  = '{8'h41, 32'h80000002, 32'h80001003, 32'h0,        32'h0,        0, 32'h04, 32'h80000002, 32'hBFC00380, 1};
    vecs[2]  = '{8'h10, 32'h80000010, 32'h0,        32'h0,        32'h0,        1, 32'h0c, 32'h80000002, 32'hBFC00380, 1};
    vecs[3]  = '{8'h20, 32'h80000020, 32'h80001004, 32'h0,        32'h0,        0, 32'h04, 32'h80001004, 32'hBFC00380, 1};
    vecs[4]  = '{8'h40, 32'h80000024, 32'h80002008, 32'h0,        32'h0,        0, 32'h05, 32'h80002008, 32'hBFC00380, 1};
    vecs[5]  = '{8'h08, 32'h80000028, 32'h0,        32'h0,        32'h0,        0, 32'h09, 32'h80002008, 32'hBFC00380, 1};
    vecs[6]  = '{8'h06, 32'h8000002c, 32'h0,        32'h0,        32'h0,        1, 32'h0a, 32'h80002008, 32'hBFC00380, 1};
    vecs[7]  = '{8'h0c, 32'h80000030, 32'h0,        32'h0,        32'h0,        0, 32'h08, 32'h80002008, 32'hBFC00380, 1};
    vecs[8]  = '{8'h50, 32'h80000034, 32'h80002100, 32'h0,        32'h0,        0, 32'h0c, 32'h80002008, 32'hBFC00380, 1};
    vecs[9]  = '{8'h80, 32'h80000038, 32'h0,        32'hBFC00200, 32'h0,        0, 32'h0e, 32'h80002008, 32'hBFC00200, 1};
    vecs[10] = '{8'h60, 32'h8000003c, 32'h80003000, 32'h0,        32'h0,        0, 32'h04, 32'h80003000, 32'hBFC00380, 1};
    vecs[11] = '{8'h00, 32'h80000040, 32'h80004000, 32'h0,        32'h0,        0, 32'h00, 32'h80003000, 32'h0,        0};
    vecs[12] = '{8'h04, 32'h80000044, 32'h0,        32'h0,        32'h0000FF03, 0, 32'h08, 32'h80003000, 32'hBFC00380, 1};

    rst = 1'b1; valid_i = 1'b0; stall_i = 1'b0; pc_i = '0; is_in_delayslot_i = 1'b0;
    mem_addr_i = '0; exc_flags_i = '0; int_i = '0; status_i = '0; cause_i = '0; epc_i = '0;
    tick(); tick();
    chk("rst_type", et1, 32'h0);
    chk("rst_flush", {31'h0, fl1}, 32'h0);
    chk("rst_addr", ia1, 32'h0);
    chk("rst_bad", bad1, 32'h0);
    chk("rst_newpc", np1, 32'h0);
    chk("rst_intp", {31'h0, ip1}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      pc_i = vecs[i].pc; mem_addr_i = vecs[i].mem; epc_i = vecs[i].epc;
      status_i = vecs[i].status; is_in_delayslot_i = vecs[i].ds;
      exc_flags_i = vecs[i].flags; valid_i = 1'b1;
      tick();
      chk($sformatf("v%0d_type", i), et1, vecs[i].e_type);
      chk($sformatf("v%0d_flush", i), {31'h0, fl1}, {31'h0, vecs[i].e_flush});
      chk($sformatf("v%0d_bad", i), bad1, vecs[i].e_bad);
      chk($sformatf("v%0d_type3", i), et3, vecs[i].e_type);
      if (vecs[i].e_flush) begin
        chk($sformatf("v%0d_newpc", i), np1, vecs[i].e_newpc);
        chk($sformatf("v%0d_addr", i), ia1, vecs[i].pc);
        chk($sformatf("v%0d_ds", i), {31'h0, ds1}, {31'h0, vecs[i].ds});
      end
      idle(1);
      chk($sformatf("v%0d_after_flush", i), {31'h0, fl1}, 32'h0);
      chk($sformatf("v%0d_after_type", i), et1, 32'h0);
      idle(2);
      status_i = '0; is_in_delayslot_i = 1'b0;
    end

    // interrupt through the synchroniser; beats eret in the same cycle
    status_i = 32'h0000FF01; int_i = 6'b000001;
    tick();
    chk("int_sync_1", {31'h0, ip1}, 32'h0);
    tick();
    chk("int_sync_2", {31'h0, ip1}, 32'h1);
    tick();
    chk("int_novalid", {31'h0, fl1}, 32'h0);
    pc_i = 32'h80000100; epc_i = 32'hBFC00200; exc_flags_i = 8'h80; valid_i = 1'b1;
    tick();
    chk("int_type", et1, 32'h01);
    chk("int_flush", {31'h0, fl1}, 32'h1);
    chk("int_newpc", np1, 32'hBFC00380);
    chk("int_addr", ia1, 32'h80000100);
    idle(3);
    status_i = 32'h0000FF03;
    #1;
    chk("int_exl_pend", {31'h0, ip1}, 32'h0);
    valid_i = 1'b1;
    tick();
    chk("int_exl_flush", {31'h0, fl1}, 32'h0);
    idle(3);
    int_i = '0; status_i = '0;
    idle(3);

    // eret held under stall
    pc_i = 32'h80000200; epc_i = 32'hBFC00200; exc_flags_i = 8'h80; valid_i = 1'b1; stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_%0d", k), {31'h0, fl1}, 32'h0);
    end
    stall_i = 1'b0;
    tick();
    chk("stall_rel_flush", {31'h0, fl1}, 32'h1);
    chk("stall_rel_type", et1, 32'h0e);
    chk("stall_rel_newpc", np1, 32'hBFC00200);
    idle(4);

    // back-to-back sys: drain 1 vs drain 3
    rst = 1'b1; tick(); rst = 1'b0;
    pc_i = 32'h80000300; exc_flags_i = 8'h04; valid_i = 1'b1;
    begin
      logic [4:0] e1, e3;
      e1 = 5'b10101; e3 = 5'b10001;
      for (int k = 0; k < 5; k++) begin
        tick();
        chk($sformatf("b2b_d1_%0d", k), {31'h0, fl1}, {31'h0, e1[4-k]});
        chk($sformatf("b2b_d3_%0d", k), {31'h0, fl3}, {31'h0, e3[4-k]});
      end
    end
    // u3 is now in its drain; reset must abort it
    rst = 1'b1;
    tick();
    chk("rstflush_type", et3, 32'h0);
    chk("rstflush_flush", {31'h0, fl3}, 32'h0);
    chk("rstflush_addr", ia3, 32'h0);
    rst = 1'b0;
    tick();
    chk("rstflush_idle", {31'h0, fl3}, 32'h1);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
